// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode encodings, immediate formats and field positions
// used by the decode stage and its instruction decoder.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_W      = 5;
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7B5   = 30;

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } immFmt_t;

endpackage

// File: rtl/instruction_decoder.sv
// Combinational RV32I field extraction, opcode classification and immediate generation.
module instruction_decoder
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0]  instr,
  output opcode_t          opcode,
  output logic [2:0]       funct3,
  output logic             funct7b5,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic             usesRs1,
  output logic             usesRs2,
  output logic             regWrite,
  output logic             illegal,
  output logic [XLEN-1:0]  imm
);

  immFmt_t fmt;
  logic    writesRd;

  assign opcode   = opcode_t'(instr[OPCODE_LSB +: 7]);
  assign funct3   = instr[FUNCT3_LSB +: 3];
  assign funct7b5 = instr[FUNCT7B5];
  assign rs1      = instr[RS1_LSB +: REG_W];
  assign rs2      = instr[RS2_LSB +: REG_W];
  assign rd       = instr[RD_LSB +: REG_W];
  assign regWrite = writesRd && (rd != '0);

  always_comb begin
    illegal  = 1'b0;
    usesRs1  = 1'b0;
    usesRs2  = 1'b0;
    writesRd = 1'b0;
    fmt      = IMM_NONE;
    case (opcode)
      OPC_LUI:      begin writesRd = 1'b1; fmt = IMM_U; end
      OPC_AUIPC:    begin writesRd = 1'b1; fmt = IMM_U; end
      OPC_JAL:      begin writesRd = 1'b1; fmt = IMM_J; end
      OPC_JALR:     begin writesRd = 1'b1; usesRs1 = 1'b1; fmt = IMM_I; end
      OPC_BRANCH:   begin usesRs1 = 1'b1; usesRs2 = 1'b1; fmt = IMM_B; end
      OPC_LOAD:     begin writesRd = 1'b1; usesRs1 = 1'b1; fmt = IMM_I; end
      OPC_STORE:    begin usesRs1 = 1'b1; usesRs2 = 1'b1; fmt = IMM_S; end
      OPC_OP_IMM:   begin writesRd = 1'b1; usesRs1 = 1'b1; fmt = IMM_I; end
      OPC_OP:       begin writesRd = 1'b1; usesRs1 = 1'b1; usesRs2 = 1'b1; end
      OPC_MISC_MEM: ;
      OPC_SYSTEM:   ;
      default:      illegal = 1'b1;
    endcase
    // Compressed encodings are not supported; an illegal word must not stall or write.
    if (instr[1:0] != 2'b11) begin
      illegal  = 1'b1;
      usesRs1  = 1'b0;
      usesRs2  = 1'b0;
      writesRd = 1'b0;
      fmt      = IMM_NONE;
    end
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: single-entry holding register with fetch/execute handshake,
// register-file address steering and a per-register busy scoreboard for RAW/WAW stalls.
module decode_stage
  import riscv_pkg::*;
(
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_FetchValid,
  output logic             o_FetchReady,
  input  logic [XLEN-1:0]  i_FetchInstr,
  input  logic [XLEN-1:0]  i_FetchPc,
  output logic [REG_W-1:0] o_RegSource1,
  output logic [REG_W-1:0] o_RegSource2,
  input  logic [XLEN-1:0]  i_RegData1,
  input  logic [XLEN-1:0]  i_RegData2,
  input  logic             i_WbValid,
  input  logic [REG_W-1:0] i_WbRd,
  input  logic             i_Flush,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [XLEN-1:0]  o_Pc,
  output opcode_t          o_Opcode,
  output logic [2:0]       o_Funct3,
  output logic             o_Funct7b5,
  output logic [REG_W-1:0] o_Rd,
  output logic             o_RegWrite,
  output logic [XLEN-1:0]  o_Rs1Data,
  output logic [XLEN-1:0]  o_Rs2Data,
  output logic [XLEN-1:0]  o_Imm,
  output logic             o_Illegal
);

  logic             r_Full;
  logic [XLEN-1:0]  r_Instr;
  logic [XLEN-1:0]  r_Pc;
  logic [31:0]      r_Busy;
  logic [31:0]      busyNext;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             usesRs1;
  logic             usesRs2;
  logic             hazard;
  logic             issue;
  logic             accept;

  instruction_decoder u_Decoder (
    .instr    (r_Instr),
    .opcode   (o_Opcode),
    .funct3   (o_Funct3),
    .funct7b5 (o_Funct7b5),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (o_Rd),
    .usesRs1  (usesRs1),
    .usesRs2  (usesRs2),
    .regWrite (o_RegWrite),
    .illegal  (o_Illegal),
    .imm      (o_Imm)
  );

  // The decoder already zeroes the use/write flags of illegal words, so they never stall.
  assign hazard = (usesRs1 && r_Busy[rs1]) || (usesRs2 && r_Busy[rs2]) ||
                  (o_RegWrite && r_Busy[o_Rd]);

  assign o_Valid      = r_Full && !hazard && !i_Flush;
  assign issue        = o_Valid && i_Ready;
  assign o_FetchReady = !i_Flush && (!r_Full || issue);
  assign accept       = i_FetchValid && o_FetchReady;

  assign o_RegSource1 = accept ? i_FetchInstr[RS1_LSB +: REG_W] : rs1;
  assign o_RegSource2 = accept ? i_FetchInstr[RS2_LSB +: REG_W] : rs2;
  assign o_Rs1Data    = i_RegData1;
  assign o_Rs2Data    = i_RegData2;
  assign o_Pc         = r_Pc;

  // Retire clears first so that a same-cycle issue to the same register wins.
  always_comb begin
    busyNext = r_Busy;
    if (i_WbValid && (i_WbRd != '0)) busyNext[i_WbRd] = 1'b0;
    if (issue && o_RegWrite) busyNext[o_Rd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Full  <= 1'b0;
      r_Instr <= '0;
      r_Pc    <= '0;
      r_Busy  <= '0;
    end else begin
      r_Busy <= busyNext;
      if (i_Flush) begin
        r_Full <= 1'b0;
      end else if (accept) begin
        r_Full  <= 1'b1;
        r_Instr <= i_FetchInstr;
        r_Pc    <= i_FetchPc;
      end else if (issue) begin
        r_Full <= 1'b0;
      end
    end
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the RV32I pipeline, sitting between fetch and execute. Accepts one fetched instruction at a time, drives the register file read addresses, and issues decoded control, immediate and operand data to execute. A register scoreboard stalls issue until in-flight writes to needed registers have retired.

## Interface
- Parameters: none. RV32I only; XLEN is fixed at 32.
- `i_Clock` in 1: single clock. All state updates on the rising edge.
- `i_Reset` in 1: synchronous, active-high reset.
- `i_FetchValid` in 1: fetch presents an instruction.
- `o_FetchReady` out 1: decode accepts the instruction this cycle.
- `i_FetchInstr` in 32: raw instruction word.
- `i_FetchPc` in 32: PC of that instruction.
- `o_RegSource1`, `o_RegSource2` out 5: register file read addresses.
- `i_RegData1`, `i_RegData2` in 32: register file read data, available one cycle after the address.
- `i_WbValid` in 1: writeback retires a register write this cycle.
- `i_WbRd` in 5: destination of that retiring write.
- `i_Flush` in 1: squash the held instruction (execute redirect).
- `o_Valid` out 1: decoded instruction is available to execute.
- `i_Ready` in 1: execute accepts it.
- `o_Pc` out 32: PC of the issued instruction.
- `o_Opcode` out `opcode_t`: opcode class.
- `o_Funct3` out 3: funct3 field.
- `o_Funct7b5` out 1: instruction bit 30.
- `o_Rd` out 5: destination register.
- `o_RegWrite` out 1: instruction writes `o_Rd`.
- `o_Rs1Data`, `o_Rs2Data` out 32: operand data, passed through from `i_RegData1`/`i_RegData2`.
- `o_Imm` out 32: sign-extended immediate.
- `o_Illegal` out 1: opcode is unrecognised.

## Operation
- State consists of the holding register (`r_Full`, `r_Instr`, `r_Pc`) and the 32-bit scoreboard `r_Busy`. Bit 0 of `r_Busy` is never set.
- Accept: `o_FetchReady = !i_Flush && (!r_Full || issue)`.
  - On `i_FetchValid && o_FetchReady`, load `r_Instr`/`r_Pc` and set `r_Full`.
- Read addresses:
  - In the accepting cycle, `o_RegSource1`/`o_RegSource2` are taken from `i_FetchInstr`.
  - In all other cycles they come from `r_Instr`.
  - Holding the addresses during a stall means the register file re-reads every cycle, so operand data stays current, including same-cycle write-through of retiring writes.
- Decode is combinational from `r_Instr`.
  - Opcode classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM.
  - Illegal: any other opcode, or `instr[1:0] != 2'b11`.
  - Uses rs1: JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - Uses rs2: BRANCH, STORE, OP.
  - `o_RegWrite`: LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, and only when rd != 0.
  - Immediate formats: I, S, B, U, J per the ISA. Always sign-extended from `instr[31]`. U-type has its low 12 bits zero. B- and J-type have bit 0 zero. All other opcodes give 0.
- Hazard: `(usesRs1 && r_Busy[rs1]) || (usesRs2 && r_Busy[rs2]) || (o_RegWrite && r_Busy[rd])`. The rd term prevents WAW.
  - Illegal instructions check no hazards and write nothing.
- Issue:
  - `o_Valid = r_Full && !hazard && !i_Flush`.
  - `issue = o_Valid && i_Ready`.
  - On issue without a new accept, clear `r_Full`.
- Scoreboard:
  - On issue with `o_RegWrite`, set `r_Busy[o_Rd]`.
  - On `i_WbValid && i_WbRd != 0`, clear `r_Busy[i_WbRd]`.
  - If both target the same bit in one cycle, set wins.
- Flush: clear `r_Full`. No accept and no issue that cycle. `r_Busy` is unaffected, because older instructions still retire.
- Reset:
  - `r_Full` = 0, `r_Busy` = 0, `r_Instr` = 0, `r_Pc` = 0.
  - `o_Valid` = 0 and `o_FetchReady` = 1.
  - Decoded outputs reflect the zero instruction (illegal). They are don't-care while `o_Valid` = 0.
- Reset takes priority over flush, and flush over issue and accept.

## Timing
- Latency: accept on edge N, so `o_Valid` can be high in cycle N+1 with valid operand data.
- Throughput: one instruction per cycle, with no bubble on back-to-back issue/accept.
- Retire-to-issue: writeback clears a bit on edge N, so a dependent instruction can issue in cycle N+1 with the written value.
- Combinational paths, by design:
  - `i_Ready` to `o_FetchReady`.
  - `i_Flush` to `o_FetchReady` and `o_Valid`.
  - `i_FetchInstr` to `o_RegSource*`.
  - `i_RegData*` to `o_Rs*Data`.
- `o_Valid`, once high, stays high with stable outputs until issue, flush or reset.

## Structure
- `riscv_pkg` holds:
  - `opcode_t` enum with the 7-bit encodings.
  - Immediate-format constants.
  - Field slice positions.
- Sub-module `instruction_decoder` (combinational) takes the instruction word and produces opcode, rs1, rs2, rd, use and regwrite flags, immediate and illegal.
- `decode_stage` holds the handshake, address mux and scoreboard.

## Test plan
- `0x00500093` (addi x1,x0,5) accepted with `i_Ready` = 1 → next cycle `o_Valid` = 1, OP_IMM, rd = 1, imm = 5, RegWrite = 1, and `r_Busy[1]` set.
- `0x002081B3` (add x3,x1,x2) issued while x1 is busy → `o_Valid` stays 0. `i_WbValid` with rd = 1 on edge N → `o_Valid` = 1 in cycle N+1, with `o_Rs1Data` equal to the written value.
- `0xFE208EE3` (beq x1,x2,-4) → imm = `0xFFFFFFFC`, RegWrite = 0, `o_RegSource1` = 1, `o_RegSource2` = 2.
- `0x00512623` (sw x5,12(x2)) followed by `0x00812283` (lw x5,8(x2)) with `i_Ready` held high → both issue in consecutive cycles, imm = 12 then 8, and `o_FetchReady` stays 1 throughout.
- Stalled instruction with `i_Flush` pulsed → `o_Valid` = 0 the same cycle, `r_Full` = 0 next cycle, and `r_Busy` unchanged.
- Word `0x00000000` → `o_Illegal` = 1, issues with no hazard stall, RegWrite = 0. Reset asserted mid-stall → `o_Valid` = 0 and `r_Busy` = 0 next cycle.
